// File: rtl/game_pkg.sv
// Shared whack-a-mole state encodings and default timing.
// Used by the game FSM and the datapath.
package game_pkg;

  typedef enum logic [3:0] {
    S_START = 4'd0,
    S_GAME  = 4'd1,
    S_MOLE1 = 4'd2,
    S_MOLE2 = 4'd3,
    S_MOLE3 = 4'd4,
    S_MOLE4 = 4'd5,
    S_OVER  = 4'd6
  } state_e;

  localparam int unsigned CLK_PER_SEC_DEF  = 50_000_000;
  localparam int unsigned GAME_SECONDS_DEF = 30;
  localparam int unsigned GAP_TICKS_DEF    = 25_000_000;
  localparam int unsigned MOLE_TICKS_DEF   = 50_000_000;

  function automatic logic is_mole(input logic [3:0] s);
    return (s >= S_MOLE1) && (s <= S_MOLE4);
  endfunction

  function automatic logic [3:0] hole_led(input logic [3:0] s);
    return is_mole(s) ? (4'b0001 << (s - 4'd2)) : 4'b0000;
  endfunction

endpackage

// File: rtl/game_datapath_if.sv
// FSM-facing bundle of the whack-a-mole datapath.
// master = game FSM / board side, slave = datapath.
interface game_datapath_if;
  logic [3:0] state;
  logic [3:0] key;
  logic       control_signal;
  logic       timer_signal;
  logic [3:0] mole_led;
  logic [7:0] score;
  logic [7:0] misses;
  logic [5:0] seconds_left;

  modport master (
    output state, key,
    input  control_signal, timer_signal, mole_led,
    input  score, misses, seconds_left
  );

  modport slave (
    input  state, key,
    output control_signal, timer_signal, mole_led,
    output score, misses, seconds_left
  );
endinterface

// File: rtl/game_timer.sv
// Game seconds countdown with sticky expiry flag.
// Clears while i_clear; counts only while i_run.
module game_timer
  import game_pkg::*;
#(
  parameter int unsigned CLK_PER_SEC  = CLK_PER_SEC_DEF,
  parameter int unsigned GAME_SECONDS = GAME_SECONDS_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_run,
  input  logic       i_clear,
  output logic [5:0] o_seconds_left,
  output logic       o_expired
);

  localparam int TW =
    (CLK_PER_SEC > 1) ? $clog2(CLK_PER_SEC) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(CLK_PER_SEC - 1);

  logic [TW-1:0] r_tick;
  logic [5:0]    r_sec;
  logic          r_exp;

  always_ff @(posedge clk) begin
    if (reset || i_clear) begin
      r_tick <= '0;
      r_sec  <= 6'(GAME_SECONDS);
      r_exp  <= 1'b0;
    end else begin
      if (r_sec == 6'd0) r_exp <= 1'b1;
      if (i_run && r_sec != 6'd0) begin
        if (r_tick == TICK_LAST) begin
          r_tick <= '0;
          r_sec  <= r_sec - 6'd1;
        end else begin
          r_tick <= r_tick + 1'b1;
        end
      end
    end
  end

  assign o_seconds_left = r_sec;
  assign o_expired      = r_exp;

endmodule

// File: rtl/game_datapath.sv
// Whack-a-mole datapath: key sync, mole/gap timing,
// score/miss counters and FSM handshake pulses.
module game_datapath
  import game_pkg::*;
#(
  parameter int unsigned CLK_PER_SEC  = CLK_PER_SEC_DEF,
  parameter int unsigned GAME_SECONDS = GAME_SECONDS_DEF,
  parameter int unsigned GAP_TICKS    = GAP_TICKS_DEF,
  parameter int unsigned MOLE_TICKS   = MOLE_TICKS_DEF
) (
  input logic      clk,
  input logic      reset,
  game_datapath_if.slave bus
);

  localparam int GW = $clog2(GAP_TICKS + 1);
  localparam int MW = $clog2(MOLE_TICKS + 1);
  localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_TICKS - 1);
  localparam logic [MW-1:0] MOLE_LAST = MW'(MOLE_TICKS - 1);

  logic [3:0]    r_sync1, r_sync2, r_kprev;
  logic [1:0]    r_arm;
  logic [3:0]    r_prev_state, r_pend_state;
  logic          r_pending, r_ctrl, r_tprev;
  logic [7:0]    r_score, r_miss;
  logic [GW-1:0] r_gap;
  logic [MW-1:0] r_mole;

  logic [3:0]    w_state, w_led, w_edge;
  logic          w_start, w_game, w_mole, w_run;
  logic          w_entry, w_pend, w_timer;
  logic          w_hit, w_expire, w_tend, w_gfire, w_fire;
  logic [GW-1:0] w_gap_cur;
  logic [MW-1:0] w_mole_cur;
  logic [5:0]    w_secs;

  // Edges are ignored until the synchronizer holds real key data.
  always_comb begin
    w_state = (bus.state > 4'd6) ? S_START : bus.state;
    w_start = (w_state == S_START);
    w_game  = (w_state == S_GAME);
    w_mole  = is_mole(w_state);
    w_run   = w_game | w_mole;
    w_led   = hole_led(w_state);
    w_edge  = r_sync2 & ~r_kprev & {4{r_arm == 2'd3}};
    w_entry = (w_state != r_prev_state);
    w_pend  = r_pending && (w_state == r_pend_state);
    w_gap_cur  = w_entry ? '0 : r_gap;
    w_mole_cur = w_entry ? '0 : r_mole;
    w_hit    = w_mole && !w_pend && |(w_edge & w_led);
    w_expire = w_mole && !w_pend && (w_mole_cur == MOLE_LAST);
    w_tend   = w_mole && !w_pend && w_timer && !r_tprev;
    w_gfire  = w_game && !w_pend && (w_gap_cur == GAP_LAST);
    w_fire   = w_hit | w_expire | w_tend | w_gfire;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1      <= '0;
      r_sync2      <= '0;
      r_kprev      <= '0;
      r_arm        <= '0;
      r_prev_state <= S_START;
      r_pend_state <= S_START;
      r_pending    <= 1'b0;
      r_ctrl       <= 1'b0;
      r_tprev      <= 1'b0;
      r_score      <= '0;
      r_miss       <= '0;
      r_gap        <= '0;
      r_mole       <= '0;
    end else begin
      r_sync1      <= bus.key;
      r_sync2      <= r_sync1;
      r_kprev      <= r_sync2;
      if (r_arm != 2'd3) r_arm <= r_arm + 2'd1;
      r_prev_state <= w_state;
      r_tprev      <= w_timer;
      r_ctrl       <= w_fire;
      if (w_start) begin
        r_pending <= 1'b0;
        r_score   <= '0;
        r_miss    <= '0;
        r_gap     <= '0;
        r_mole    <= '0;
      end else begin
        r_pending <= w_pend | w_fire;
        if (w_fire) r_pend_state <= w_state;
        if (w_game && !w_pend) r_gap <= w_gap_cur + 1'b1;
        if (w_mole && !w_pend) r_mole <= w_mole_cur + 1'b1;
        if (w_hit && r_score != 8'hFF)
          r_score <= r_score + 8'd1;
        if (w_expire && !w_hit && r_miss != 8'hFF)
          r_miss <= r_miss + 8'd1;
      end
    end
  end

  game_timer #(
    .CLK_PER_SEC  (CLK_PER_SEC),
    .GAME_SECONDS (GAME_SECONDS)
  ) u_timer (
    .clk            (clk),
    .reset          (reset),
    .i_run          (w_run),
    .i_clear        (w_start),
    .o_seconds_left (w_secs),
    .o_expired      (w_timer)
  );

  assign bus.control_signal = r_ctrl;
  assign bus.timer_signal   = w_timer;
  assign bus.mole_led       = w_led;
  assign bus.score          = r_score;
  assign bus.misses         = r_miss;
  assign bus.seconds_left   = w_secs;

endmodule

// File: tb/tb_game_datapath.sv
// Randomized bench for game_datapath with a
// window-level reference model of hits and misses.
module tb_game_datapath;
  import game_pkg::*;

  localparam int CPS  = 10;
  localparam int GS   = 3;
  localparam int GAP  = 4;
  localparam int MOLE = 6;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   n_run = 0;
  int   n_fail = 0;
  int   exp_score, exp_miss, t_run;
  int   pq[$];
  bit   exp_p[1:40];

  always #5 clk = ~clk;

  game_datapath_if bus();

  game_datapath #(
    .CLK_PER_SEC  (CPS),
    .GAME_SECONDS (GS),
    .GAP_TICKS    (GAP),
    .MOLE_TICKS   (MOLE)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d want %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic go_start();
    bus.state = S_START;
    bus.key   = '0;
    step();
    step();
    exp_score = 0;
    exp_miss  = 0;
    t_run     = 0;
    check("start_score", bus.score, 0);
    check("start_miss", bus.misses, 0);
    check("start_sec", bus.seconds_left, GS);
    check("start_timer", bus.timer_signal, 0);
  endtask

  // One mole window: key bit kbit first sampled on edge k.
  task automatic mole_window(input int hole, input int kbit,
                             input int k, input int len);
    int pulses, at, exp_at;
    bit hit;
    logic [3:0] e_led;
    pulses = 0;
    at     = -1;
    e_led  = 4'b0001 << hole;
    bus.state = 4'(hole + 2);
    for (int j = 1; j <= len; j++) begin
      if (j == k) bus.key[kbit] = 1'b1;
      if (j == k + 2) bus.key = '0;
      step();
      if (j == 1) check("led", bus.mole_led, e_led);
      if (bus.control_signal) begin
        pulses++;
        at = j;
      end
    end
    hit    = (kbit == hole) && (k + 2 <= MOLE);
    exp_at = hit ? k + 2 : MOLE;
    if (hit) exp_score++;
    else exp_miss++;
    t_run += len;
    check("mw_pulses", pulses, 1);
    check("mw_pulse_at", at, exp_at);
    check("mw_score", bus.score, exp_score);
    check("mw_miss", bus.misses, exp_miss);
    check("mw_sec", bus.seconds_left, GS - t_run / CPS);
  endtask

  initial begin
    int h1, h2, kb, st;
    bus.state = S_START;
    bus.key   = '0;
    repeat (3) step();
    reset = 1'b0;
    step();
    check("rst_ctrl", bus.control_signal, 0);
    check("rst_score", bus.score, 0);
    check("rst_miss", bus.misses, 0);
    check("rst_sec", bus.seconds_left, GS);
    check("rst_timer", bus.timer_signal, 0);
    check("rst_led", bus.mole_led, 0);

    // Full game: gap, miss and timeout pulses.
    go_start();
    pq = '{GAP, 9 + MOLE - 1, 15 + GAP - 1,
           19 + MOLE - 1, 25 + GAP - 1, GS * CPS + 2};
    foreach (pq[i]) exp_p[pq[i]] = 1'b1;
    for (int e = 1; e <= 36; e++) begin
      if (e <= 8)       st = 1;
      else if (e <= 14) st = 2;
      else if (e <= 18) st = 1;
      else if (e <= 24) st = 3;
      else if (e <= 28) st = 1;
      else              st = 5;
      bus.state = 4'(st);
      if (e == 6) bus.key[0] = 1'b1;
      if (e == 8) bus.key = '0;
      step();
      check("g_pulse", bus.control_signal, exp_p[e]);
      check("g_sec", bus.seconds_left,
            (e >= GS * CPS) ? 0 : GS - e / CPS);
      check("g_timer", bus.timer_signal, e > GS * CPS);
    end
    check("g_score", bus.score, 0);
    check("g_miss", bus.misses, 2);
    bus.state = S_OVER;
    repeat (3) begin
      step();
      check("over_ctrl", bus.control_signal, 0);
    end
    check("over_miss", bus.misses, 2);
    check("over_sec", bus.seconds_left, 0);
    check("over_timer", bus.timer_signal, 1);
    bus.state = S_START;
    step();
    check("clr_timer", bus.timer_signal, 0);
    check("clr_sec", bus.seconds_left, GS);
    check("clr_miss", bus.misses, 0);

    // Directed hit, wrong key, late hit, too-late hit.
    go_start();
    mole_window(1, 1, 1, 8);
    go_start();
    mole_window(1, 0, 1, 8);
    mole_window(2, 2, 4, 8);
    mole_window(3, 3, 5, 8);

    repeat (10) begin
      go_start();
      h1 = int'($urandom_range(0, 3));
      h2 = (h1 + int'($urandom_range(1, 3))) % 4;
      kb = $urandom_range(0, 1) ? h1 : int'($urandom_range(0, 3));
      mole_window(h1, kb, int'($urandom_range(1, 6)),
                  int'($urandom_range(8, 12)));
      kb = $urandom_range(0, 1) ? h2 : int'($urandom_range(0, 3));
      mole_window(h2, kb, int'($urandom_range(1, 6)),
                  int'($urandom_range(8, 12)));
    end

    // Reset mid-mole with a hit in flight and key held.
    go_start();
    bus.state = S_GAME;
    repeat (12) step();
    check("pre_rst_sec", bus.seconds_left, GS - 1);
    bus.state = S_MOLE2;
    for (int j = 1; j <= 3; j++) begin
      if (j == 2) bus.key[1] = 1'b1;
      step();
    end
    reset = 1'b1;
    step();
    check("mr_ctrl", bus.control_signal, 0);
    check("mr_score", bus.score, 0);
    check("mr_miss", bus.misses, 0);
    check("mr_sec", bus.seconds_left, GS);
    check("mr_timer", bus.timer_signal, 0);
    check("mr_led", bus.mole_led, 4'b0010);
    reset = 1'b0;
    repeat (5) begin
      step();
      check("mr_nohit", bus.control_signal, 0);
    end
    check("mr_score2", bus.score, 0);
    bus.key   = '0;
    bus.state = S_START;
    step();

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
